ising_axi_host: RTL and testbench

Host-side initiator for the Ising machine register interface; it drives the write strobe and read-address channels that `ising_axi` responds to. A single command runs one full anneal: program the counter registers, pulse the machine out of reset, wait a programmable number of cycles, then read back all N phase bits. It sits between a test or host sequencer and `ising_axi`. It replaces hand-written bus sequencing in benches and on-chip controllers.

---
 rtl/ising_axi_host.sv | 185 ++++++++++++++++++
 tb/tb_ising_axi_host.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ising_axi_host.sv
// rtl/ising_axi_host.sv - host initiator running one full anneal on ising_axi per command
// Writes counters, restarts the machine, waits R cycles, then reads back all N phase bits.
module ising_axi_host #(
  parameter int          N               = 3,
  parameter int          RD_TIMEOUT      = 16,
  parameter logic [31:0] START_ADDR      = 32'h0000_0000,
  parameter logic [31:0] CTR_CUTOFF_ADDR = 32'h0000_0004,
  parameter logic [31:0] CTR_MAX_ADDR    = 32'h0000_0008,
  parameter logic [31:0] PHASE_ADDR_BASE = 32'h0000_0100
) (
  input  logic         clk,
  input  logic         axi_rstn,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [31:0]  cmd_cutoff,
  input  logic [31:0]  cmd_max,
  input  logic [31:0]  cmd_run_cycles,
  input  logic         cmd_abort,
  output logic         busy,
  output logic         res_valid,
  output logic [N-1:0] res_phase,
  output logic         res_error,
  output logic         wready,
  output logic [31:0]  wr_addr,
  output logic [31:0]  wdata,
  output logic         arvalid_q,
  output logic [31:0]  araddr_q,
  output logic         rready,
  input  logic         rvalid,
  input  logic         rresp,
  input  logic [31:0]  rdata
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [TW-1:0] T_LAST   = TW'(RD_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_CUTOFF, S_WR_MAX, S_WR_RSTLO, S_WR_START,
    S_RUN, S_RD_ADDR, S_RD_WAIT, S_ABORT, S_DONE
  } state_t;

  state_t         state, state_nxt;
  logic [31:0]    cutoff_q, cutoff_nxt;
  logic [31:0]    max_q, max_nxt;
  logic [31:0]    cnt, cnt_nxt;
  logic [IW-1:0]  idx, idx_nxt;
  logic [TW-1:0]  tcnt, tcnt_nxt;
  logic           err, err_nxt;
  logic           pend, pend_nxt;
  logic [N-1:0]   phase_nxt;
  logic           wready_nxt, arvalid_nxt;
  logic [31:0]    wr_addr_nxt, wdata_nxt, araddr_nxt;

  logic unused_rdata;
  assign unused_rdata = ^rdata[31:1];

  always_comb begin
    state_nxt  = state;
    cutoff_nxt = cutoff_q;
    max_nxt    = max_q;
    cnt_nxt    = cnt;
    idx_nxt    = idx;
    tcnt_nxt   = tcnt;
    err_nxt    = err;
    pend_nxt   = pend;
    phase_nxt  = res_phase;
    case (state)
      S_IDLE: if (cmd_valid) begin
        state_nxt  = S_WR_CUTOFF;
        cutoff_nxt = cmd_cutoff;
        max_nxt    = cmd_max;
        cnt_nxt    = cmd_run_cycles;
        idx_nxt    = '0;
        err_nxt    = 1'b0;
        pend_nxt   = 1'b0;
        phase_nxt  = '0;
      end
      S_WR_CUTOFF: state_nxt = cmd_abort ? S_ABORT : S_WR_MAX;
      S_WR_MAX:    state_nxt = cmd_abort ? S_ABORT : S_WR_RSTLO;
      S_WR_RSTLO:  state_nxt = cmd_abort ? S_ABORT : S_WR_START;
      S_WR_START: begin
        if (cmd_abort)         state_nxt = S_ABORT;
        else if (cnt == 32'd0) state_nxt = S_RD_ADDR;
        else                   state_nxt = S_RUN;
      end
      S_RUN: begin
        if (cmd_abort) state_nxt = S_ABORT;
        else begin
          cnt_nxt = cnt - 32'd1;
          if (cnt == 32'd1) state_nxt = S_RD_ADDR;
        end
      end
      S_RD_ADDR: begin
        pend_nxt  = pend | cmd_abort;
        tcnt_nxt  = '0;
        state_nxt = S_RD_WAIT;
      end
      // An abort here only takes effect after the outstanding read resolves.
      S_RD_WAIT: begin
        pend_nxt = pend | cmd_abort;
        if (rvalid) begin
          phase_nxt[idx] = rdata[0];
          if (rresp) err_nxt = 1'b1;
          if (pend_nxt)               state_nxt = S_ABORT;
          else if (idx == LAST_IDX)   state_nxt = S_DONE;
          else begin
            idx_nxt   = idx + 1'b1;
            state_nxt = S_RD_ADDR;
          end
        end else if (tcnt == T_LAST) begin
          err_nxt   = 1'b1;
          state_nxt = pend_nxt ? S_ABORT : S_DONE;
        end else begin
          tcnt_nxt = tcnt + 1'b1;
        end
      end
      S_ABORT: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (state_nxt == S_ABORT) err_nxt = 1'b1;

    // Outputs are decoded from the next state so that they register alongside it.
    wready_nxt  = 1'b0;
    wr_addr_nxt = 32'd0;
    wdata_nxt   = 32'd0;
    case (state_nxt)
      S_WR_CUTOFF: begin wready_nxt = 1'b1; wr_addr_nxt = CTR_CUTOFF_ADDR; wdata_nxt = cutoff_nxt; end
      S_WR_MAX:    begin wready_nxt = 1'b1; wr_addr_nxt = CTR_MAX_ADDR;    wdata_nxt = max_nxt;    end
      S_WR_RSTLO:  begin wready_nxt = 1'b1; wr_addr_nxt = START_ADDR;      wdata_nxt = 32'd0;      end
      S_WR_START:  begin wready_nxt = 1'b1; wr_addr_nxt = START_ADDR;      wdata_nxt = 32'd1;      end
      S_ABORT:     begin wready_nxt = 1'b1; wr_addr_nxt = START_ADDR;      wdata_nxt = 32'd0;      end
      default: ;
    endcase
    arvalid_nxt = (state_nxt == S_RD_ADDR);
    araddr_nxt  = arvalid_nxt ? (PHASE_ADDR_BASE + (32'(idx_nxt) << 2)) : 32'd0;
  end

  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      state     <= S_IDLE;
      cutoff_q  <= 32'd0;
      max_q     <= 32'd0;
      cnt       <= 32'd0;
      idx       <= '0;
      tcnt      <= '0;
      err       <= 1'b0;
      pend      <= 1'b0;
      res_phase <= '0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      res_error <= 1'b0;
      wready    <= 1'b0;
      wr_addr   <= 32'd0;
      wdata     <= 32'd0;
      arvalid_q <= 1'b0;
      araddr_q  <= 32'd0;
      rready    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cutoff_q  <= cutoff_nxt;
      max_q     <= max_nxt;
      cnt       <= cnt_nxt;
      idx       <= idx_nxt;
      tcnt      <= tcnt_nxt;
      err       <= err_nxt;
      pend      <= pend_nxt;
      res_phase <= phase_nxt;
      cmd_ready <= (state_nxt == S_IDLE);
      busy      <= (state_nxt != S_IDLE);
      res_valid <= (state_nxt == S_DONE);
      res_error <= (state_nxt == S_DONE) & err_nxt;
      wready    <= wready_nxt;
      wr_addr   <= wr_addr_nxt;
      wdata     <= wdata_nxt;
      arvalid_q <= arvalid_nxt;
      araddr_q  <= araddr_nxt;
      rready    <= (state_nxt == S_RD_WAIT);
    end
  end

endmodule

// File: tb/tb_ising_axi_host.sv
// tb/tb_ising_axi_host.sv - bench for ising_axi_host with a register responder and timing model
module tb_ising_axi_host;

  localparam int          N    = 3;
  localparam int          TMO  = 16;
  localparam logic [31:0] A_ST = 32'h0000_0000;
  localparam logic [31:0] A_CU = 32'h0000_0004;
  localparam logic [31:0] A_MX = 32'h0000_0008;
  localparam logic [31:0] A_PH = 32'h0000_0100;

  logic         clk, axi_rstn;
  logic         cmd_valid, cmd_ready, cmd_abort, busy;
  logic [31:0]  cmd_cutoff, cmd_max, cmd_run_cycles;
  logic         res_valid, res_error;
  logic [N-1:0] res_phase;
  logic         wready, arvalid_q, rready, rvalid, rresp;
  logic [31:0]  wr_addr, wdata, araddr_q, rdata;

  ising_axi_host #(.N(N), .RD_TIMEOUT(TMO), .START_ADDR(A_ST), .CTR_CUTOFF_ADDR(A_CU),
                   .CTR_MAX_ADDR(A_MX), .PHASE_ADDR_BASE(A_PH)) dut (
    .clk(clk), .axi_rstn(axi_rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_cutoff(cmd_cutoff), .cmd_max(cmd_max), .cmd_run_cycles(cmd_run_cycles),
    .cmd_abort(cmd_abort), .busy(busy), .res_valid(res_valid), .res_phase(res_phase),
    .res_error(res_error), .wready(wready), .wr_addr(wr_addr), .wdata(wdata),
    .arvalid_q(arvalid_q), .araddr_q(araddr_q), .rready(rready), .rvalid(rvalid),
    .rresp(rresp), .rdata(rdata));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] cutoff, max, run;
    logic [N-1:0] bits;
    int stall, errb, abort_c;
    int exp_cyc;
    logic [N-1:0] exp_phase;
    logic exp_err;
  } vec_t;
  typedef struct { int cyc; logic [31:0] addr; logic [31:0] data; } wr_t;

  int errors = 0, checks = 0;

  // Register responder: answers one read the edge after arvalid_q, can stall or flag a bit.
  logic [N-1:0] resp_bits = '0;
  int           resp_stall = -1, resp_errb = -1;
  logic [31:0]  rd_idx;
  assign rd_idx = (araddr_q - A_PH) >> 2;
  always @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      rvalid <= 1'b0; rresp <= 1'b0; rdata <= 32'd0;
    end else if (rvalid && rready) begin
      rvalid <= 1'b0;
    end else if (arvalid_q && int'(rd_idx) != resp_stall) begin
      rvalid <= 1'b1;
      rdata  <= {31'd0, resp_bits[rd_idx[1:0]]};
      rresp  <= (int'(rd_idx) == resp_errb);
    end
  end

  // Negedge observer: cycle numbers are relative to the accept edge (cycle 0).
  wr_t          wq[$];
  int           ncyc = 0, acc_n = 0, rv_cnt = 0, rv_cyc = -1, rdy_cyc = -1, viol = 0;
  logic [N-1:0] rv_phase = '0;
  logic         rv_err = 1'b0;
  always @(negedge clk) begin
    ncyc <= ncyc + 1;
    if (axi_rstn) begin
      if (wready) wq.push_back('{ncyc - acc_n, wr_addr, wdata});
      if (res_valid) begin
        rv_cnt <= rv_cnt + 1; rv_cyc <= ncyc - acc_n; rv_phase <= res_phase; rv_err <= res_error;
      end
      if (cmd_ready && rdy_cyc < 0 && ncyc > acc_n) rdy_cyc <= ncyc - acc_n;
      if ((!wready && (wr_addr != 0 || wdata != 0)) || (!arvalid_q && araddr_q != 0) ||
          (arvalid_q && rvalid && rready) || (busy == cmd_ready))
        viol <= viol + 1;
      if (cmd_valid && cmd_ready) begin
        acc_n <= ncyc; wq.delete(); rv_cnt <= 0; rv_cyc <= -1; rdy_cyc <= -1;
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model of one command: write trace, result cycle, phases and error.
  wr_t exp_wq[$];
  function automatic void add_w(input int c, input logic [31:0] a, input logic [31:0] d);
    exp_wq.push_back('{c, a, d});
  endfunction

  function automatic void model(input vec_t v, output int vcyc, output logic [N-1:0] ph,
                                output logic er);
    int rr, t;
    rr = int'(v.run);
    exp_wq.delete();
    ph = '0; er = 1'b0;
    add_w(1, A_CU, v.cutoff); add_w(2, A_MX, v.max); add_w(3, A_ST, 0); add_w(4, A_ST, 1);
    if (v.abort_c >= 1 && v.abort_c <= 4 + rr) begin
      while (exp_wq.size() > 0 && exp_wq[$].cyc > v.abort_c) void'(exp_wq.pop_back());
      add_w(v.abort_c + 1, A_ST, 0);
      vcyc = v.abort_c + 2; er = 1'b1;
      return;
    end
    for (int i = 0; i < N; i++) begin
      t = 5 + rr + 2 * i;
      if (i == v.stall) begin
        er = 1'b1;
        if (v.abort_c >= t && v.abort_c <= t + TMO) begin
          add_w(t + TMO + 1, A_ST, 0); vcyc = t + TMO + 2;
        end else vcyc = t + TMO + 1;
        return;
      end
      ph[i] = v.bits[i];
      if (i == v.errb) er = 1'b1;
      if (v.abort_c == t || v.abort_c == t + 1) begin
        add_w(t + 2, A_ST, 0); vcyc = t + 3; er = 1'b1;
        return;
      end
    end
    vcyc = 5 + rr + 2 * N;
  endfunction

  task automatic run_vec(input vec_t v, input int probe);
    int c;
    resp_bits = v.bits; resp_stall = v.stall; resp_errb = v.errb;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_cutoff = v.cutoff; cmd_max = v.max; cmd_run_cycles = v.run;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_cutoff = $urandom; cmd_max = $urandom; cmd_run_cycles = $urandom;
    c = 1;
    while (rv_cnt == 0 && c < 200) begin
      cmd_abort = (c == v.abort_c);
      cmd_valid = (c == probe);
      @(posedge clk); #1;
      c++;
    end
    cmd_abort = 1'b0; cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_vec(input vec_t v, input int k);
    int bad;
    chk($sformatf("v%0d_res_valid_cycle", k), rv_cyc, v.exp_cyc);
    chk($sformatf("v%0d_res_valid_pulses", k), rv_cnt, 1);
    chk($sformatf("v%0d_res_phase", k), rv_phase, v.exp_phase);
    chk($sformatf("v%0d_res_error", k), rv_err, v.exp_err);
    chk($sformatf("v%0d_cmd_ready_cycle", k), rdy_cyc, v.exp_cyc + 1);
    bad = (wq.size() == exp_wq.size()) ? 0 : 1;
    for (int i = 0; i < wq.size() && i < exp_wq.size(); i++)
      if (wq[i].cyc != exp_wq[i].cyc || wq[i].addr !== exp_wq[i].addr || wq[i].data !== exp_wq[i].data)
        bad++;
    chk($sformatf("v%0d_write_trace_mismatches", k), bad, 0);
  endtask

  vec_t vecs[16];
  int   mc;
  logic [N-1:0] mp;
  logic me;

  initial begin
    axi_rstn = 1'b0; cmd_valid = 1'b0; cmd_abort = 1'b0;
    cmd_cutoff = 0; cmd_max = 0; cmd_run_cycles = 0;
    //            cutoff   max     R   bits   stall errb abort  cyc phase err
    vecs[0] = '{32'h10, 32'h40, 32'd8, 3'b101, -1, -1,  0, 19, 3'b101, 1'b0};
    vecs[1] = '{32'h10, 32'h40, 32'd0, 3'b101, -1, -1,  0, 11, 3'b101, 1'b0};
    vecs[2] = '{32'h11, 32'h22, 32'd8, 3'b101,  1, -1,  0, 32, 3'b001, 1'b1};
    vecs[3] = '{32'h33, 32'h44, 32'd8, 3'b101, -1,  2,  0, 19, 3'b101, 1'b1};
    vecs[4] = '{32'h55, 32'h66, 32'd8, 3'b111, -1, -1,  7,  9, 3'b000, 1'b1};
    vecs[5] = '{32'h77, 32'h88, 32'd8, 3'b011, -1, -1, 16, 18, 3'b011, 1'b1};
    vecs[6] = '{32'h99, 32'haa, 32'd4, 3'b110, -1, -1,  2,  4, 3'b000, 1'b1};
    vecs[7] = '{32'hbb, 32'hcc, 32'd2, 3'b111,  0, -1, 10, 25, 3'b000, 1'b1};
    for (int k = 8; k < 16; k++) begin
      vecs[k].cutoff  = $urandom; vecs[k].max = $urandom;
      vecs[k].run     = 32'($urandom_range(0, 12));
      vecs[k].bits    = N'($urandom);
      vecs[k].stall   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N - 1)) : -1;
      vecs[k].errb    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N - 1)) : -1;
      vecs[k].abort_c = ($urandom_range(0, 2) == 0) ?
                        int'($urandom_range(1, 5 + vecs[k].run + 2 * N)) : 0;
      model(vecs[k], mc, mp, me);
      vecs[k].exp_cyc = mc; vecs[k].exp_phase = mp; vecs[k].exp_err = me;
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", {cmd_ready, busy, wready, arvalid_q, rready, res_valid, res_error, res_phase}, 10'h200);
    chk("reset_buses", wr_addr | wdata | araddr_q, 0);
    @(posedge clk); #1;
    axi_rstn = 1'b1;

    for (int k = 0; k < 16; k++) begin
      model(vecs[k], mc, mp, me);
      run_vec(vecs[k], 0);
      check_vec(vecs[k], k);
    end

    // Reset arriving mid-command, during the WR_MAX write.
    resp_bits = 3'b101; resp_stall = -1; resp_errb = -1;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_cutoff = 32'h1234; cmd_max = 32'h5678; cmd_run_cycles = 5;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_reset_wr_max", {wready, wr_addr, wdata}, {1'b1, A_MX, 32'h5678});
    axi_rstn = 1'b0;
    #1;
    chk("reset_async_strobes", {wready, cmd_ready, busy}, 3'b010);
    repeat (2) @(posedge clk);
    #1; axi_rstn = 1'b1;
    @(negedge clk);
    chk("post_reset_ctrl", {cmd_ready, busy, wready, arvalid_q, rready, res_valid, res_error, res_phase}, 10'h200);
    chk("post_reset_buses", wr_addr | wdata | araddr_q, 0);
    repeat (30) @(posedge clk);
    #1;
    chk("no_partial_res_valid", rv_cnt, 0);

    model(vecs[0], mc, mp, me);
    run_vec(vecs[0], 3);
    check_vec(vecs[0], 16);
    repeat (40) @(posedge clk);
    #1;
    chk("busy_cmd_not_queued", rv_cnt, 1);
    chk("idle_after_busy_cmd", {cmd_ready, busy}, 2'b10);
    chk("protocol_violations", viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
